// File: rtl/scc_run_ctrl.sv
// Run controller for the SCC core: sequences core reset, gates the core clock
// enable, captures halt/watchdog termination and latches error flags per run.
module scc_run_ctrl #(
    parameter int RST_CYCLES   = 3,
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] wdog_limit,
    input  logic             halt_f,
    input  logic [1:0]       err_bits,
    output logic             core_rst,
    output logic             core_clk_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [1:0]       err_latched,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_CLEAN = 2'b01;
    localparam logic [1:0] ST_ERR   = 2'b10;
    localparam logic [1:0] ST_WDOG  = 2'b11;

    // One phase counter serves both the RESET hold and the DRAIN window.
    localparam int PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] RST_LAST   = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? PH_W'(DRAIN_CYCLES - 1) : '0;

    state_t            state, nxt;
    logic [PH_W-1:0]   ph_cnt;
    logic [CNT_W-1:0]  wdog_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [1:0]        err_acc;
    logic              wdog_hit;

    assign cnt_inc  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    assign wdog_hit = (wdog_q != '0) && (cnt_inc == wdog_q);
    assign err_acc  = err_latched | err_bits;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start && !abort) nxt = S_RESET;
            S_RESET: begin
                if (abort)                 nxt = S_IDLE;
                else if (ph_cnt == RST_LAST) nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)       nxt = S_IDLE;
                else if (halt_f) nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                else if (wdog_hit) nxt = S_DONE;
            end
            S_DRAIN: begin
                if (abort)                     nxt = S_IDLE;
                else if (ph_cnt == DRAIN_LAST) nxt = S_DONE;
            end
            S_DONE: begin
                if (abort)      nxt = S_IDLE;
                else if (start) nxt = S_RESET;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ph_cnt      <= '0;
            wdog_q      <= '0;
            core_rst    <= 1'b1;
            core_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= ST_NONE;
            err_latched <= 2'b00;
            cycle_count <= '0;
        end else begin
            state       <= nxt;
            ph_cnt      <= (nxt != state) ? '0 : ph_cnt + PH_W'(1);
            // Outputs decoded from the next state so they line up with it.
            core_rst    <= (nxt == S_IDLE) || (nxt == S_RESET);
            core_clk_en <= (nxt == S_RESET) || (nxt == S_RUN) || (nxt == S_DRAIN);
            busy        <= (nxt == S_RESET) || (nxt == S_RUN) || (nxt == S_DRAIN);
            done        <= (nxt == S_DONE);

            case (state)
                S_IDLE, S_DONE: begin
                    if (nxt == S_RESET) begin
                        cycle_count <= '0;
                        err_latched <= 2'b00;
                        status      <= ST_NONE;
                        wdog_q      <= wdog_limit;
                    end else if (nxt == S_IDLE) begin
                        status      <= ST_NONE;
                    end
                end
                S_RESET, S_RUN, S_DRAIN: begin
                    err_latched <= err_acc;
                    if (state == S_RUN)
                        cycle_count <= cnt_inc;
                    if (nxt == S_IDLE)
                        status <= ST_NONE;
                    else if (nxt == S_DONE) begin
                        // Watchdog is the only RUN->DONE exit without halt.
                        if (state == S_RUN && !halt_f) status <= ST_WDOG;
                        else status <= (err_acc != 2'b00) ? ST_ERR : ST_CLEAN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Directed bench for scc_run_ctrl with default parameters (RST 3, DRAIN 1).
module tb_scc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] wdog_limit = '0;
    logic        halt_f = 1'b0;
    logic [1:0]  err_bits = 2'b00;
    logic        core_rst, core_clk_en, busy, done;
    logic [1:0]  status, err_latched;
    logic [31:0] cycle_count;

    int n_chk = 0;
    int n_err = 0;

    scc_run_ctrl #(.RST_CYCLES(3), .DRAIN_CYCLES(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wdog_limit(wdog_limit), .halt_f(halt_f), .err_bits(err_bits),
        .core_rst(core_rst), .core_clk_en(core_clk_en), .busy(busy),
        .done(done), .status(status), .err_latched(err_latched),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues start at the next edge, then steps through the 3 RESET edges.
    task automatic begin_run(input logic [31:0] lim);
        wdog_limit = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(3);
    endtask

    task automatic pulse_halt();
        halt_f = 1'b1;
        tick();
        halt_f = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_clk_en", core_clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_err", err_latched, 0);
        chk("rst_count", cycle_count, 0);
        rst = 1'b1;
        tick();

        // Clean run: start at edge 0, halt on 60th RUN edge (edge 63)
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clean_k_core_rst", core_rst, 1);
        chk("clean_k_clk_en", core_clk_en, 1);
        chk("clean_k_busy", busy, 1);
        tick(2);
        chk("clean_k2_core_rst", core_rst, 1);
        tick();
        chk("clean_k3_core_rst", core_rst, 0);
        tick(59);
        chk("clean_cnt59", cycle_count, 59);
        pulse_halt();
        chk("clean_h_count", cycle_count, 60);
        chk("clean_h_clk_en", core_clk_en, 1);
        chk("clean_h_done", done, 0);
        tick();
        chk("clean_done", done, 1);
        chk("clean_clk_en", core_clk_en, 0);
        chk("clean_core_rst", core_rst, 0);
        chk("clean_status", status, 2'b01);
        chk("clean_count", cycle_count, 60);
        chk("clean_busy", busy, 0);

        // Restart from DONE, start ignored in RUN, error at RUN edge 10, halt at 20
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_count_clr", cycle_count, 0);
        chk("rs_status_clr", status, 0);
        chk("rs_busy", busy, 1);
        chk("rs_done", done, 0);
        tick(3);
        tick(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_core_rst", core_rst, 0);
        chk("ign_start_count", cycle_count, 5);
        tick(4);
        err_bits = 2'b10;
        tick();
        err_bits = 2'b00;
        chk("err_latch", err_latched, 2'b10);
        chk("err_busy", busy, 1);
        tick(9);
        pulse_halt();
        chk("err_h_count", cycle_count, 20);
        tick();
        chk("err_done", done, 1);
        chk("err_status", status, 2'b10);
        chk("err_hold", err_latched, 2'b10);

        // Watchdog at 100, restarting from DONE clears err_latched
        wdog_limit = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_err_clr", err_latched, 0);
        wdog_limit = 32'd5;
        tick(3);
        tick(99);
        chk("wd_99_done", done, 0);
        chk("wd_99_count", cycle_count, 99);
        tick();
        chk("wd_done", done, 1);
        chk("wd_clk_en", core_clk_en, 0);
        chk("wd_status", status, 2'b11);
        chk("wd_count", cycle_count, 100);

        // Halt on the watchdog edge: halt wins
        begin_run(32'd100);
        tick(99);
        pulse_halt();
        chk("wdh_count", cycle_count, 100);
        chk("wdh_drain_done", done, 0);
        chk("wdh_clk_en", core_clk_en, 1);
        tick();
        chk("wdh_done", done, 1);
        chk("wdh_status", status, 2'b01);

        // Abort from DONE: status clears, count holds
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("dab_done", done, 0);
        chk("dab_status", status, 0);
        chk("dab_count", cycle_count, 100);
        chk("dab_core_rst", core_rst, 1);

        // Abort at RUN edge 5
        begin_run(32'd0);
        tick(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_core_rst", core_rst, 1);
        chk("ab_clk_en", core_clk_en, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_status", status, 0);

        // start+abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_core_rst", core_rst, 1);
        tick();
        chk("sa_busy2", busy, 0);

        // Async reset mid-RUN, between edges
        begin_run(32'd0);
        tick(7);
        err_bits = 2'b01;
        tick();
        err_bits = 2'b00;
        #2 rst = 1'b0;
        #1;
        chk("ar_core_rst", core_rst, 1);
        chk("ar_clk_en", core_clk_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_count", cycle_count, 0);
        chk("ar_err", err_latched, 0);
        tick();
        rst = 1'b1;
        tick();
        begin_run(32'd0);
        tick(2);
        pulse_halt();
        tick();
        chk("ar_run_done", done, 1);
        chk("ar_run_status", status, 2'b01);
        chk("ar_run_count", cycle_count, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scc_run_ctrl.md
# scc_run_ctrl

Run controller for the SCC core (`scc_f25_top`). It sequences core reset, gates the core clock enable, and turns the one-cycle `halt_f` pulse into a sticky done/status indication. It also accumulates `err_bits`, counts executed cycles and enforces a watchdog. It sits between the system/test harness and the core, so halt capture and run termination live in hardware rather than in each bench.

## Interface
- `RST_CYCLES`, default 3: cycles the core is held in reset (with clock enabled) after `start`; must be ≥1.
- `DRAIN_CYCLES`, default 1: cycles the core keeps running after `halt_f` so final writebacks land; 0 allowed.
- `CNT_W`, default 32: width of `cycle_count` and `wdog_limit`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = reset).
- `start`  in  1  run request, sampled in IDLE and DONE only.
- `abort`  in  1  cancel run, returns to IDLE.
- `wdog_limit`  in  CNT_W  max RUN cycles; 0 disables watchdog; sampled on `start`.
- `halt_f`  in  1  core halt pulse (may be one cycle wide).
- `err_bits`  in  2  core error flags.
- `core_rst`  out  1  active-high reset to core.
- `core_clk_en`  out  1  clock enable to core.
- `busy`  out  1  high in RESET/RUN/DRAIN.
- `done`  out  1  high in DONE.
- `status`  out  2  00 none, 01 halted clean, 10 halted with error, 11 watchdog timeout.
- `err_latched`  out  2  sticky OR of `err_bits` over the current run.
- `cycle_count`  out  CNT_W  RUN cycles executed this run.

## Operation
- All outputs are registered, Moore-style, decoded from state and counters.
- States: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE: `core_rst`=1, `core_clk_en`=0.
  - `start`&!`abort` → RESET.
  - On that transition: clear `cycle_count`, `err_latched`, `status`; capture `wdog_limit`.
- RESET: `core_rst`=1, `core_clk_en`=1 for exactly RST_CYCLES cycles, then → RUN.
- RUN: `core_rst`=0, `core_clk_en`=1.
  - `cycle_count` increments on every edge in RUN (saturates at all-ones).
  - Transition priority per edge: `abort` → IDLE, else `halt_f` → DRAIN (DONE if DRAIN_CYCLES=0), else watchdog hit → DONE with `status`=11.
  - Watchdog hit: limit≠0 and incremented count == limit.
- DRAIN: `core_rst`=0, `core_clk_en`=1 for DRAIN_CYCLES cycles, `cycle_count` frozen, then → DONE.
- Halt path `status` is written on DONE entry: 10 if `err_latched` (including the entry-edge OR) ≠0, else 01.
- `err_bits` is ORed into `err_latched` on every edge in RESET, RUN and DRAIN. An error does not stop the run.
- DONE: `core_rst`=0 (core state held for memory inspection), `core_clk_en`=0.
  - `done`=1; `status`, `cycle_count`, `err_latched` held.
  - `start`&!`abort` → RESET (restart, clears as in IDLE). `abort` → IDLE.
- `abort` in RESET/DRAIN → IDLE. `abort` in IDLE is ignored. `abort` beats `start` on the same edge.
- IDLE entry by abort clears `status` to 00; `cycle_count`/`err_latched` hold until the next start.
- `start` while busy is ignored.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, `core_rst`=1, `core_clk_en`=0, `busy`=0, `done`=0, `status`=00, `err_latched`=00, `cycle_count`=0.
- Reset mid-run takes effect without a clock edge.
- `start` sampled at edge k: `core_rst`=1, `core_clk_en`=1, `busy`=1 after edge k.
- `core_rst` falls after edge k+RST_CYCLES.
- `halt_f` sampled at edge h: `core_clk_en` stays 1 until edge h+DRAIN_CYCLES, then 0; `done`=1 after the same edge.
- `cycle_count` includes the halt edge.
- A single-cycle `halt_f` pulse is never missed in RUN. `halt_f` outside RUN is ignored.
- Watchdog hit at edge w: `core_clk_en`=0 and `done`=1 after edge w; `cycle_count`=limit.
- Halt and watchdog hit on the same edge: halt wins (DRAIN, `status` 01/10).

## Test plan
- Clean run: RST_CYCLES=3, DRAIN_CYCLES=1, `wdog_limit`=0, `start` at edge 0, `halt_f` pulse on 60th RUN edge → `core_rst` low edges 3..63, `done`=1 and `core_clk_en`=0 after edge 64, `status`=01, `cycle_count`=60.
- Error run: `err_bits`=10 for one cycle at RUN edge 10, halt at edge 20 → run continues to halt, `err_latched`=10, `status`=10, `cycle_count`=20.
- Watchdog: `wdog_limit`=100, no halt → `done`=1 after 100th RUN edge, `status`=11, `cycle_count`=100. Repeat with halt on edge 100 → `status`=01.
- Abort: `abort` at RUN edge 5 → next cycle IDLE, `core_rst`=1, `core_clk_en`=0, `busy`=0, `done`=0, `status`=00. `start`+`abort` same edge in IDLE → stays IDLE.
- Async reset: drive `rst` low mid-RUN between edges → all outputs at reset values immediately; release, `start` → normal run.
- Restart and ignore: `start` during RUN has no effect. `start` in DONE → RESET with `cycle_count`=0, `err_latched`=00, `status`=00, second clean run completes with `status`=01.
